// File: rtl/prog_fetch_rom.sv
// Writable program store with a program-counter fetch engine that streams
// instruction words to the datapath over a valid/ready handshake.
module prog_fetch_rom #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 4,
   parameter int END_ADDR = 8,
   parameter int WRAP     = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              start,
   input  logic              halt,
   input  logic              jump_en,
   input  logic [ADDR_W-1:0] jump_addr,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [DATA_W-1:0] instr_data,
   output logic [ADDR_W-1:0] instr_addr,
   output logic              busy,
   output logic              done
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] END_A = ADDR_W'(END_ADDR);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state, next_state;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              load_en;
   logic              drop_valid;
   logic [ADDR_W-1:0] load_addr;
   logic [DATA_W-1:0] load_word;
   logic              accept;
   logic              at_end;

   always_comb begin
      next_state = state;
      load_en    = 1'b0;
      drop_valid = 1'b0;
      load_addr  = '0;
      accept     = instr_valid && instr_ready;
      at_end     = (instr_addr >= END_A);
      case (state)
         IDLE: begin
            if (!halt && start) begin
               load_en    = 1'b1;
               next_state = RUN;
            end
         end
         RUN: begin
            if (halt) begin
               drop_valid = 1'b1;
               next_state = IDLE;
            end else if (jump_en) begin
               load_en   = 1'b1;
               load_addr = jump_addr;
            end else if (accept) begin
               if (!at_end) begin
                  load_en   = 1'b1;
                  load_addr = instr_addr + 1'b1;
               end else if (WRAP != 0) begin
                  load_en = 1'b1;
               end else begin
                  drop_valid = 1'b1;
                  next_state = DONE;
               end
            end
         end
         DONE: begin
            if (halt) begin
               next_state = IDLE;
            end else if (start) begin
               load_en    = 1'b1;
               next_state = RUN;
            end
         end
         default: next_state = IDLE;
      endcase
      // A same-cycle write to the word being fetched wins over the stored copy.
      load_word = (wr_en && (wr_addr == load_addr)) ? wr_data : mem[load_addr];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         instr_valid <= 1'b0;
         instr_data  <= '0;
         instr_addr  <= '0;
      end else begin
         state <= next_state;
         if (load_en) begin
            instr_data  <= load_word;
            instr_addr  <= load_addr;
            instr_valid <= 1'b1;
         end else if (drop_valid) begin
            instr_valid <= 1'b0;
         end
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: doc/prog_fetch_rom.md
Name: prog_fetch_rom

Overview:
Parametrised program store with a sequencing fetch engine. It replaces the fixed combinational program table with a writable register-file memory plus a program counter. The counter streams instruction words to the datapath over a valid/ready handshake and supports start, halt, jump, end-of-program detection and optional wrap. It sits between the loader/testbench side and the MCU datapath that consumes 16-bit operand-packed instruction words.

Parameters:
DATA_W, 16, instruction word width
ADDR_W, 4, address width; DEPTH = 2**ADDR_W words
END_ADDR, 8, last valid program address (must be < DEPTH)
WRAP, 0, 1 = restart at address 0 after END_ADDR; 0 = stop in DONE

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
wr_en  in  1  loader write strobe, accepted in any state
wr_addr  in  ADDR_W  loader write address
wr_data  in  DATA_W  loader write data
start  in  1  begin fetch from address 0 (IDLE or DONE only)
halt  in  1  abort the fetch stream, return to IDLE
jump_en  in  1  redirect the stream (RUN only)
jump_addr  in  ADDR_W  jump target
instr_valid  out  1  instr_data/instr_addr hold a valid word
instr_ready  in  1  consumer accepts the word when valid && ready
instr_data  out  DATA_W  instruction word
instr_addr  out  ADDR_W  address of instr_data
busy  out  1  1 while in RUN
done  out  1  1 while in DONE

Behaviour:
- Reset (async, immediate): state = IDLE; all memory words = 0; instr_valid = 0; instr_data = 0; instr_addr = 0; busy = 0; done = 0.
- Memory: DEPTH x DATA_W registers.
  - wr_en writes mem[wr_addr] at the clock edge in every state.
  - Write-first bypass: if the word loaded into instr_data in the same cycle has address == wr_addr with wr_en = 1, the loaded value is wr_data.
- Outputs are registered. A load means: instr_data <= mem[a], instr_addr <= a, instr_valid <= 1.
- Priority, high to low: halt > jump_en > start/advance.
- State IDLE:
  - start = 1 -> load a = 0, go to RUN (first word valid 1 cycle after start).
  - jump_en is ignored.
- State RUN (busy = 1):
  - halt -> instr_valid <= 0, go to IDLE.
  - else jump_en -> load a = jump_addr. The current word is discarded even if it is accepted the same cycle.
  - else valid && ready && instr_addr < END_ADDR -> load a = instr_addr + 1.
  - else valid && ready && instr_addr >= END_ADDR:
    - WRAP = 1 -> load a = 0, stay in RUN.
    - WRAP = 0 -> instr_valid <= 0, go to DONE.
  - else (not ready) -> instr_data/instr_addr/instr_valid held stable. A write to the held address does not modify the held word.
- State DONE (done = 1, instr_valid = 0):
  - start -> load a = 0, go to RUN.
  - halt -> go to IDLE.
- Throughput: one word per cycle with ready held high.
- A jump target > END_ADDR is legal: that word is delivered, and the next acceptance triggers the end-of-program rule.
- start while in RUN is ignored.
- Reset asserted mid-stream: instr_valid drops immediately and the memory contents are lost.

Test Plan:
- Reset, load mem[0..8] = 1234, 2138, 1256, 7757, 7758, 7758, 7759, 7758, 7750 (hex), WRAP = 0, ready = 1, pulse start -> words 0..8 delivered on 9 consecutive cycles; instr_addr 0..8; then done = 1, instr_valid = 0.
- Same program, ready toggled 1,0,0,1 -> word at addr 1 (2138) held stable for the two stalled cycles; no word skipped or duplicated.
- WRAP = 1, END_ADDR = 2, ready = 1 -> address sequence 0,1,2,0,1,2…; done stays 0.
- During RUN at addr 3, jump_en with jump_addr = 6 and ready = 1 -> next word is 7759 @ addr 6; word 7757 is not followed by addr 4.
- halt and jump_en asserted together -> IDLE, instr_valid = 0 next cycle. Then wr_en to addr 0 with 0xABCD in the same cycle as start -> first delivered word is ABCD.
- Assert rst asynchronously mid-stream (between clock edges) -> all outputs 0 immediately; after release, start yields 0000 @ addr 0.
